// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue fed by dispatch and the CDB.
// It retires at most one done head entry per cycle and serves operand tag lookups.
module reorder_buffer #(
    parameter int DEPTH = 16,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_reg_write,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic [TAG_W-1:0] q_tag,
    output logic             q_ready,
    output logic [31:0]      q_data,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [4:0]       commit_rd,
    output logic             commit_reg_write,
    output logic [31:0]      commit_data,
    output logic [TAG_W:0]   count
);
    logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, rw_q, rw_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             alloc_fire, cdb_fire, q_hit;

    // alloc_ready looks only at occupancy, so a full ROB refuses even while committing
    assign alloc_ready      = count_q != (TAG_W+1)'(DEPTH);
    assign alloc_tag        = tail_q;
    assign alloc_fire       = alloc_valid & alloc_ready & ~flush;
    assign cdb_fire         = cdb_valid & valid_q[cdb_tag] & ~flush;
    assign commit_valid     = valid_q[head_q] & done_q[head_q] & ~flush;
    assign commit_tag       = commit_valid ? head_q : '0;
    assign commit_rd        = commit_valid ? rd_q[head_q] : '0;
    assign commit_reg_write = commit_valid & rw_q[head_q] & (rd_q[head_q] != 5'd0);
    assign commit_data      = commit_valid ? data_q[head_q] : '0;
    assign q_hit            = cdb_valid & (cdb_tag == q_tag);
    assign q_ready          = valid_q[q_tag] & (done_q[q_tag] | q_hit);
    assign q_data           = !q_ready ? '0 : q_hit ? cdb_data : data_q[q_tag];
    assign count            = count_q;

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rw_d    = rw_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_valid);
        if (cdb_fire) begin
            done_d[cdb_tag] = 1'b1;
            data_d[cdb_tag] = cdb_data;
        end
        if (commit_valid) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + TAG_W'(1);
        end
        if (alloc_fire) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            rw_d[tail_q]    = alloc_reg_write;
            rd_d[tail_q]    = alloc_rd;
            data_d[tail_q]  = '0;
            tail_d          = tail_q + TAG_W'(1);
        end
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            done_q  <= '0;
            rw_q    <= '0;
            rd_q    <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            rw_q    <= rw_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random traffic against a program-order queue model.
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic             clk = 1'b0, reset = 1'b0, flush = 1'b0;
    logic             alloc_valid = 1'b0, alloc_reg_write = 1'b0, cdb_valid = 1'b0;
    logic [4:0]       alloc_rd = '0;
    logic [TAG_W-1:0] cdb_tag = '0, q_tag = '0;
    logic [31:0]      cdb_data = '0;
    logic             alloc_ready, q_ready, commit_valid, commit_reg_write;
    logic [TAG_W-1:0] alloc_tag, commit_tag;
    logic [31:0]      q_data, commit_data;
    logic [4:0]       commit_rd;
    logic [TAG_W:0]   count;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_reg_write(alloc_reg_write),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .q_tag(q_tag), .q_ready(q_ready), .q_data(q_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_reg_write(commit_reg_write), .commit_data(commit_data), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int rd;
        bit rw;
    } ent_t;

    // Expected retirement order: every allocation is pushed here and popped on commit
    ent_t        rob[$];
    bit          m_done [DEPTH];
    logic [31:0] m_data [DEPTH];
    int          m_tail = 0;
    int          checks = 0, errors = 0;
    int          m_n;
    bit          m_exp_c, m_ql, m_byp, m_eqr;
    ent_t        m_hd;
    logic [31:0] m_eqd;

    function automatic bit live(int t);
        foreach (rob[i]) if (rob[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            rob.delete();
            m_tail = 0;
            foreach (m_done[i]) m_done[i] = 1'b0;
        end else begin
            m_n     = rob.size();
            m_hd    = m_n > 0 ? rob[0] : '{0, 0, 1'b0};
            m_exp_c = !flush && m_n > 0 && m_done[m_hd.tag];
            chk("count", 32'(count), 32'(m_n));
            chk("alloc_ready", 32'(alloc_ready), 32'(m_n < DEPTH));
            chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
            chk("commit_valid", 32'(commit_valid), 32'(m_exp_c));
            chk("commit_tag", 32'(commit_tag), m_exp_c ? 32'(m_hd.tag) : 32'd0);
            chk("commit_rd", 32'(commit_rd), m_exp_c ? 32'(m_hd.rd) : 32'd0);
            chk("commit_reg_write", 32'(commit_reg_write), 32'(m_exp_c && m_hd.rw && m_hd.rd != 0));
            chk("commit_data", commit_data, m_exp_c ? m_data[m_hd.tag] : 32'd0);
            m_ql  = live(int'(q_tag));
            m_byp = cdb_valid && cdb_tag == q_tag;
            m_eqr = m_ql && (m_done[q_tag] || m_byp);
            m_eqd = !m_eqr ? 32'd0 : m_byp ? cdb_data : m_data[q_tag];
            chk("q_ready", 32'(q_ready), 32'(m_eqr));
            chk("q_data", q_data, m_eqd);
            if (flush) begin
                rob.delete();
                m_tail = 0;
                foreach (m_done[i]) m_done[i] = 1'b0;
            end else begin
                if (cdb_valid && live(int'(cdb_tag))) begin
                    m_done[cdb_tag] = 1'b1;
                    m_data[cdb_tag] = cdb_data;
                end
                if (m_exp_c) void'(rob.pop_front());
                if (alloc_valid && m_n < DEPTH) begin
                    rob.push_back('{m_tail, int'(alloc_rd), alloc_reg_write});
                    m_done[m_tail] = 1'b0;
                    m_data[m_tail] = '0;
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    end

    task automatic drive(bit f, bit av, int ard, bit arw, bit cv, int ct, logic [31:0] cd, int qt);
        flush = f; alloc_valid = av; alloc_rd = 5'(ard); alloc_reg_write = arw;
        cdb_valid = cv; cdb_tag = TAG_W'(ct); cdb_data = cd; q_tag = TAG_W'(qt);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int pick_tag();
        if (rob.size() > 0 && $urandom_range(9) < 8) return rob[$urandom_range(rob.size() - 1)].tag;
        return int'($urandom_range(DEPTH - 1));
    endfunction

    int t0, ct;

    initial begin
        #12 reset = 1'b1;
        @(posedge clk);
        #1;
        // Out-of-order completion must still retire in order
        t0 = m_tail;
        drive(0, 1, 1, 1, 0, 0, 0, 0);
        drive(0, 1, 2, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, (t0 + 1) % DEPTH, 32'h1111_0001, (t0 + 1) % DEPTH);
        idle(2);
        drive(0, 0, 0, 0, 1, t0, 32'h1111_0000, t0);
        idle(3);
        // Single alloc with writeback, then retire next cycle
        t0 = m_tail;
        drive(0, 1, 5, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, t0, 32'hDEAD_BEEF, 0);
        idle(2);
        // Destination x0 never asserts RegWrite
        t0 = m_tail;
        drive(0, 1, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, t0, 32'h0BAD_F00D, 0);
        idle(2);
        // Fill, refuse while full (even during commit), then wrap the tail
        t0 = m_tail;
        for (int i = 0; i < DEPTH; i++) drive(0, 1, i + 1, 1, 0, 0, 0, 0);
        drive(0, 1, 9, 1, 0, 0, 0, 0);
        drive(0, 1, 9, 1, 1, t0, 32'hCAFE_0000, 0);
        drive(0, 1, 9, 1, 0, 0, 0, 0);
        drive(0, 1, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300 && rob.size() > 0; i++)
            drive(0, 0, 0, 0, 1, pick_tag(), $urandom, pick_tag());
        idle(2);
        // Same-cycle CDB bypass on the query port, then flush with entries in flight
        t0 = m_tail;
        repeat (4) drive(0, 1, 7, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, (t0 + 3) % DEPTH, 32'h1234_5678, (t0 + 3) % DEPTH);
        drive(1, 1, 3, 1, 1, t0, 32'h5555_AAAA, t0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            ct = pick_tag();
            if (i == 1500) begin
                flush = 1'b0; alloc_valid = 1'b1; cdb_valid = 1'b1; q_tag = TAG_W'(ct);
                #2 reset = 1'b0;
                #1;
                chk("rst_count", 32'(count), 32'd0);
                chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
                chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
                chk("rst_commit_valid", 32'(commit_valid), 32'd0);
                chk("rst_commit_tag", 32'(commit_tag), 32'd0);
                chk("rst_commit_rd", 32'(commit_rd), 32'd0);
                chk("rst_commit_rw", 32'(commit_reg_write), 32'd0);
                chk("rst_commit_data", commit_data, 32'd0);
                chk("rst_q_ready", 32'(q_ready), 32'd0);
                chk("rst_q_data", q_data, 32'd0);
                @(posedge clk);
                #2 reset = 1'b1;
            end
            drive($urandom_range(63) == 0,
                  $urandom_range(99) < ((i % 400) < 200 ? 80 : 30),
                  int'($urandom_range(31)), 1'($urandom),
                  $urandom_range(99) < 60, ct, $urandom,
                  $urandom_range(3) == 0 ? ct : pick_tag());
        end
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
